// File: rtl/team_06_echo_pkg.sv
// Shared types, default sizes and arithmetic helpers for the team_06 echo family.
package team_06_echo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    MIX    = 2'd2,
    WR_REQ = 2'd3
  } echo_state_e;

  localparam int DEF_SAMPLE_W    = 8;
  localparam int DEF_ADDR_W      = 13;
  localparam int DEF_DECAY_SHIFT = 1;
  localparam int DEF_TIMEOUT_CYC = 64;
  localparam int SAT_MAX_W       = 32;

  // Unsigned add clamped to the all-ones value of a w-bit word (w <= SAT_MAX_W).
  function automatic logic [SAT_MAX_W-1:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int unsigned          w
  );
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ({{SAT_MAX_W{1'b0}}, 1'b1} << w) - {{SAT_MAX_W{1'b0}}, 1'b1};
    if (sum > lim) begin
      sat_add = lim[SAT_MAX_W-1:0];
    end else begin
      sat_add = sum[SAT_MAX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/team_06_echo_mixer.sv
// Combinational echo mixer: attenuates the past sample by a right shift and
// adds it to the current sample with saturation.
module team_06_echo_mixer
  import team_06_echo_pkg::*;
#(
  parameter int W     = DEF_SAMPLE_W,
  parameter int SHIFT = DEF_DECAY_SHIFT
) (
  input  logic [W-1:0] i_audio,
  input  logic [W-1:0] i_past,
  output logic [W-1:0] o_mix
);

  logic [W-1:0] w_past_sh;

  assign w_past_sh = i_past >> SHIFT;
  assign o_mix     = W'(sat_add(SAT_MAX_W'(i_audio), SAT_MAX_W'(w_past_sh), W));

endmodule

// File: rtl/team_06_echo_engine.sv
// Echo engine: circular history in external RAM, read-mix-write per sample.
// Optional memory ack timeout is enabled by defining TEAM_06_ECHO_TIMEOUT_EN.
module team_06_echo_engine
  import team_06_echo_pkg::*;
#(
  parameter int SAMPLE_W    = DEF_SAMPLE_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DECAY_SHIFT = DEF_DECAY_SHIFT,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] audio_in,
  input  logic                echo_en,
  input  logic                feedback,
  input  logic [ADDR_W-1:0]   delay,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SAMPLE_W-1:0] mem_wdata,
  input  logic [SAMPLE_W-1:0] mem_rdata,
  input  logic                mem_ack,
  output logic [SAMPLE_W-1:0] echo_out,
  output logic                out_valid,
  output logic                busy,
`ifdef TEAM_06_ECHO_TIMEOUT_EN
  output logic                mem_timeout,
`endif
  output logic                overrun
);

  localparam logic [ADDR_W-1:0]   A_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]   A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]   A_MAX  = {ADDR_W{1'b1}};
  localparam logic [SAMPLE_W-1:0] S_ZERO = {SAMPLE_W{1'b0}};

  echo_state_e         r_state, w_state_nxt;
  logic [SAMPLE_W-1:0] r_audio, w_audio_nxt;
  logic [SAMPLE_W-1:0] r_past, w_past_nxt;
  logic [SAMPLE_W-1:0] r_echo_out, w_echo_out_nxt;
  logic [SAMPLE_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic                r_echo_en, w_echo_en_nxt;
  logic                r_feedback, w_feedback_nxt;
  logic [ADDR_W-1:0]   r_wr_ptr, w_wr_ptr_nxt;
  logic [ADDR_W-1:0]   r_fill, w_fill_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic                r_overrun, w_overrun_nxt;
  logic                r_busy;
  logic [SAMPLE_W-1:0] w_mix_raw;
  logic [SAMPLE_W-1:0] w_mix;
  logic                w_tmo_hit;

  team_06_echo_mixer #(
    .W     (SAMPLE_W),
    .SHIFT (DECAY_SHIFT)
  ) u_mixer (
    .i_audio (r_audio),
    .i_past  (r_past),
    .o_mix   (w_mix_raw)
  );

  assign w_mix = r_echo_en ? w_mix_raw : r_audio;

`ifdef TEAM_06_ECHO_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_mem_timeout;
  logic             w_in_req;

  assign w_in_req  = (r_state == RD_REQ) || (r_state == WR_REQ);
  assign w_tmo_hit = w_in_req && !mem_ack && (r_tmo_cnt == TMO_LAST);

  // Ack wait counter restarts on every entry into a request state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt     <= {TMO_W{1'b0}};
      r_mem_timeout <= 1'b0;
    end else begin
      if (w_in_req && (w_state_nxt == r_state)) begin
        r_tmo_cnt <= r_tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
      end else begin
        r_tmo_cnt <= {TMO_W{1'b0}};
      end
      r_mem_timeout <= r_mem_timeout | w_tmo_hit;
    end
  end

  assign mem_timeout = r_mem_timeout;
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Next-state and next-output logic; all memory port values are registered.
  always_comb begin
    w_state_nxt     = r_state;
    w_audio_nxt     = r_audio;
    w_echo_en_nxt   = r_echo_en;
    w_feedback_nxt  = r_feedback;
    w_past_nxt      = r_past;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_fill_nxt      = r_fill;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_echo_out_nxt  = r_echo_out;
    w_out_valid_nxt = 1'b0;
    w_overrun_nxt   = r_overrun | (sample_valid & (r_state != IDLE));

    case (r_state)
      IDLE: begin
        if (sample_valid) begin
          w_audio_nxt    = audio_in;
          w_echo_en_nxt  = echo_en;
          w_feedback_nxt = feedback;
          w_past_nxt     = S_ZERO;
          // Tap is only valid once enough history has been written.
          if (echo_en && (delay != A_ZERO) && (r_fill >= delay)) begin
            w_state_nxt    = RD_REQ;
            w_mem_req_nxt  = 1'b1;
            w_mem_we_nxt   = 1'b0;
            w_mem_addr_nxt = r_wr_ptr - delay;
          end else begin
            w_state_nxt = MIX;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RD_REQ: begin
        if (mem_ack) begin
          w_past_nxt    = mem_rdata;
          w_state_nxt   = MIX;
          w_mem_req_nxt = 1'b0;
        end else if (w_tmo_hit) begin
          w_past_nxt    = S_ZERO;
          w_state_nxt   = MIX;
          w_mem_req_nxt = 1'b0;
        end else begin
          w_state_nxt = RD_REQ;
        end
      end
      MIX: begin
        w_echo_out_nxt  = w_mix;
        w_out_valid_nxt = 1'b1;
        w_mem_wdata_nxt = r_feedback ? w_mix : r_audio;
        w_mem_addr_nxt  = r_wr_ptr;
        w_mem_we_nxt    = 1'b1;
        w_mem_req_nxt   = 1'b1;
        w_state_nxt     = WR_REQ;
      end
      WR_REQ: begin
        if (mem_ack) begin
          w_wr_ptr_nxt  = r_wr_ptr + A_ONE;
          w_fill_nxt    = (r_fill == A_MAX) ? A_MAX : (r_fill + A_ONE);
          w_state_nxt   = IDLE;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
        end else if (w_tmo_hit) begin
          w_state_nxt   = IDLE;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
        end else begin
          w_state_nxt = WR_REQ;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_mem_req_nxt = 1'b0;
        w_mem_we_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_audio     <= S_ZERO;
      r_echo_en   <= 1'b0;
      r_feedback  <= 1'b0;
      r_past      <= S_ZERO;
      r_wr_ptr    <= A_ZERO;
      r_fill      <= A_ZERO;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= A_ZERO;
      r_mem_wdata <= S_ZERO;
      r_echo_out  <= S_ZERO;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_audio     <= w_audio_nxt;
      r_echo_en   <= w_echo_en_nxt;
      r_feedback  <= w_feedback_nxt;
      r_past      <= w_past_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_fill      <= w_fill_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_echo_out  <= w_echo_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_overrun   <= w_overrun_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign echo_out  = r_echo_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_team_06_echo_engine.sv
// Directed self-checking bench for team_06_echo_engine with a behavioural
// sample RAM whose ack latency and ack withholding are controlled per test.
module tb_team_06_echo_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [7:0]  audio_in = 8'd0;
  logic        echo_en = 1'b0;
  logic        feedback = 1'b0;
  logic [12:0] delay = 13'd0;
  logic        mem_req, mem_we, mem_ack;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, echo_out;
  logic        out_valid, busy, overrun;
`ifdef TEAM_06_ECHO_TIMEOUT_EN
  logic        mem_timeout;
`endif

  int checks = 0;
  int failures = 0;

  team_06_echo_engine dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .audio_in(audio_in),
    .echo_en(echo_en), .feedback(feedback), .delay(delay),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .echo_out(echo_out), .out_valid(out_valid), .busy(busy),
`ifdef TEAM_06_ECHO_TIMEOUT_EN
    .mem_timeout(mem_timeout),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // RAM model: ack asserted in the ack_lat-th cycle of a request.
  logic [7:0]  ram [0:8191];
  int          ack_lat = 1;
  bit          ack_hold = 1'b0;
  bit          hold_rd = 1'b0;
  int          req_cnt = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  logic [12:0] last_rd_addr = 13'd0;
  logic [12:0] last_wr_addr = 13'd0;
  logic [7:0]  last_wr_data = 8'd0;

  assign mem_ack   = mem_req && !ack_hold && !(hold_rd && !mem_we) && (req_cnt >= ack_lat - 1);
  assign mem_rdata = (mem_ack && !mem_we) ? ram[mem_addr] : 8'h00;

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      req_cnt <= 0;
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        wr_count      <= wr_count + 1;
        last_wr_addr  <= mem_addr;
        last_wr_data  <= mem_wdata;
      end else begin
        rd_count     <= rd_count + 1;
        last_rd_addr <= mem_addr;
      end
    end else if (mem_req) begin
      req_cnt <= req_cnt + 1;
    end else begin
      req_cnt <= 0;
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for out_valid and then for busy to fall; lat counts negedges.
  task automatic wait_out(output int lat, output logic [7:0] eo, output bit done);
    bit seen;
    seen = 1'b0; lat = 0; eo = 8'h00; done = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      if (out_valid && !seen) begin
        seen = 1'b1; lat = i; eo = echo_out;
      end
      if (seen && !busy) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_sample(input logic [7:0] a, input logic [12:0] d, input logic en,
                            input logic fb, output int lat, output logic [7:0] eo, output bit done);
    @(negedge clk);
    audio_in = a; delay = d; echo_en = en; feedback = fb; sample_valid = 1'b1;
    wait_out(lat, eo, done);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, echo_out, out_valid, busy, overrun} !== 34'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {mem_req, mem_we, mem_addr, mem_wdata, echo_out, out_valid, busy, overrun});
    end
    @(negedge clk);
    checks++;
    if ({mem_req, busy, out_valid, overrun} !== 4'd0) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=0000", {mem_req, busy, out_valid, overrun});
    end
  endtask

  task automatic test_warmup();
    int lat; logic [7:0] eo; bit done; int rc0; int wc0;
    apply_reset();
    rc0 = rd_count; wc0 = wr_count;
    run_sample(8'd68, 13'd4, 1'b1, 1'b0, lat, eo, done);
    checks++;
    if (!done) begin failures++; $display("FAIL warm_done got=0 exp=1"); end
    checks++;
    if (rd_count !== rc0) begin failures++; $display("FAIL warm_no_read got=%0d exp=%0d", rd_count, rc0); end
    checks++;
    if (eo !== 8'd68) begin failures++; $display("FAIL warm_echo got=%0d exp=68", eo); end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL warm_latency got=%0d exp=2", lat); end
    checks++;
    if ({last_wr_addr, last_wr_data} !== {13'd0, 8'd68} || wr_count !== wc0 + 1) begin
      failures++;
      $display("FAIL warm_write got addr=%0d data=%0d n=%0d exp addr=0 data=68 n=%0d", last_wr_addr, last_wr_data, wr_count - wc0, 1);
    end
  endtask

  task automatic test_echo_read();
    int lat; logic [7:0] eo; bit done; int rc0;
    apply_reset();
    ack_lat = 1;
    run_sample(8'd10, 13'd0, 1'b0, 1'b0, lat, eo, done);
    run_sample(8'd20, 13'd0, 1'b0, 1'b0, lat, eo, done);
    run_sample(8'd30, 13'd0, 1'b0, 1'b0, lat, eo, done);
    run_sample(8'd40, 13'd0, 1'b0, 1'b0, lat, eo, done);
    rc0 = rd_count;
    ack_lat = 3;
    run_sample(8'd100, 13'd4, 1'b1, 1'b0, lat, eo, done);
    ack_lat = 1;
    checks++;
    if (rd_count !== rc0 + 1 || last_rd_addr !== 13'd0) begin
      failures++;
      $display("FAIL echo_read_addr got n=%0d addr=%0d exp n=1 addr=0", rd_count - rc0, last_rd_addr);
    end
    checks++;
    if (eo !== 8'd105) begin failures++; $display("FAIL echo_value got=%0d exp=105", eo); end
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL echo_latency got=%0d exp=5", lat); end
    checks++;
    if ({last_wr_addr, last_wr_data} !== {13'd4, 8'd100}) begin
      failures++;
      $display("FAIL echo_write got addr=%0d data=%0d exp addr=4 data=100", last_wr_addr, last_wr_data);
    end
  endtask

  task automatic test_saturation();
    int lat; logic [7:0] eo; bit done; int rc0;
    apply_reset();
    run_sample(8'd200, 13'd0, 1'b0, 1'b0, lat, eo, done);
    checks++;
    if (eo !== 8'd200) begin failures++; $display("FAIL bypass_echo got=%0d exp=200", eo); end
    run_sample(8'd250, 13'd1, 1'b1, 1'b1, lat, eo, done);
    checks++;
    if (eo !== 8'd255) begin failures++; $display("FAIL sat_echo_fb got=%0d exp=255", eo); end
    checks++;
    if ({last_rd_addr, last_wr_addr, last_wr_data} !== {13'd0, 13'd1, 8'd255}) begin
      failures++;
      $display("FAIL sat_write_fb got rd=%0d wr=%0d data=%0d exp rd=0 wr=1 data=255", last_rd_addr, last_wr_addr, last_wr_data);
    end
    run_sample(8'd250, 13'd2, 1'b1, 1'b0, lat, eo, done);
    checks++;
    if (eo !== 8'd255) begin failures++; $display("FAIL sat_echo_nofb got=%0d exp=255", eo); end
    checks++;
    if ({last_wr_addr, last_wr_data} !== {13'd2, 8'd250}) begin
      failures++;
      $display("FAIL sat_write_nofb got addr=%0d data=%0d exp addr=2 data=250", last_wr_addr, last_wr_data);
    end
    rc0 = rd_count;
    run_sample(8'd30, 13'd0, 1'b1, 1'b0, lat, eo, done);
    checks++;
    if (eo !== 8'd30 || rd_count !== rc0 || lat !== 2) begin
      failures++;
      $display("FAIL delay_zero got echo=%0d reads=%0d lat=%0d exp echo=30 reads=0 lat=2", eo, rd_count - rc0, lat);
    end
  endtask

  task automatic test_overrun_reset();
    int lat; logic [7:0] eo; bit done; int wc0; bit found;
    apply_reset();
    run_sample(8'd10, 13'd0, 1'b0, 1'b0, lat, eo, done);
    wc0 = wr_count;
    ack_hold = 1'b1;
    @(negedge clk);
    audio_in = 8'd100; delay = 13'd1; echo_en = 1'b1; feedback = 1'b0; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 13'd0}) begin
      failures++;
      $display("FAIL ovr_rd_req got req=%b we=%b addr=%0d exp req=1 we=0 addr=0", mem_req, mem_we, mem_addr);
    end
    @(negedge clk);
    audio_in = 8'd77; delay = 13'd0; echo_en = 1'b0; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1 || mem_addr !== 13'd0 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL ovr_flag got ovr=%b addr=%0d req=%b exp ovr=1 addr=0 req=1", overrun, mem_addr, mem_req);
    end
    ack_hold = 1'b0;
    wait_out(lat, eo, done);
    checks++;
    if (!done || eo !== 8'd105) begin failures++; $display("FAIL ovr_echo got=%0d done=%b exp=105", eo, done); end
    checks++;
    if (wr_count !== wc0 + 1 || {last_wr_addr, last_wr_data} !== {13'd1, 8'd100} || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_write got n=%0d addr=%0d data=%0d ovr=%b exp n=1 addr=1 data=100 ovr=1", wr_count - wc0, last_wr_addr, last_wr_data, overrun);
    end
    run_sample(8'd60, 13'd0, 1'b0, 1'b0, lat, eo, done);
    checks++;
    if (eo !== 8'd60 || {last_wr_addr, last_wr_data} !== {13'd2, 8'd60}) begin
      failures++;
      $display("FAIL ovr_next got echo=%0d addr=%0d data=%0d exp echo=60 addr=2 data=60", eo, last_wr_addr, last_wr_data);
    end
    wc0 = wr_count;
    ack_hold = 1'b1;
    @(negedge clk);
    audio_in = 8'd33; delay = 13'd0; echo_en = 1'b0; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req && mem_we) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin failures++; $display("FAIL rst_wr_reach got=0 exp=1"); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, busy, overrun} !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid_wr got req=%b busy=%b ovr=%b exp 000", mem_req, busy, overrun);
    end
    rst = 1'b0;
    ack_hold = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_count !== wc0) begin failures++; $display("FAIL rst_discard got writes=%0d exp=0", wr_count - wc0); end
    run_sample(8'd44, 13'd0, 1'b0, 1'b0, lat, eo, done);
    checks++;
    if ({last_wr_addr, last_wr_data} !== {13'd0, 8'd44}) begin
      failures++;
      $display("FAIL rst_wr_ptr got addr=%0d data=%0d exp addr=0 data=44", last_wr_addr, last_wr_data);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [7:0] eo; bit done; int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 8192; i++) begin
      run_sample(8'(i), 13'd0, 1'b0, 1'b0, lat, eo, done);
      if (!done) bad++;
    end
    checks++;
    if (bad !== 0 || last_wr_addr !== 13'd8191) begin
      failures++;
      $display("FAIL wrap_fill got stuck=%0d last_addr=%0d exp stuck=0 last_addr=8191", bad, last_wr_addr);
    end
    run_sample(8'd50, 13'd3, 1'b1, 1'b0, lat, eo, done);
    checks++;
    if (last_rd_addr !== 13'd8189) begin failures++; $display("FAIL wrap_rd_addr got=%0d exp=8189", last_rd_addr); end
    checks++;
    if (eo !== 8'd176 || last_wr_addr !== 13'd0) begin
      failures++;
      $display("FAIL wrap_echo got echo=%0d wr_addr=%0d exp echo=176 wr_addr=0", eo, last_wr_addr);
    end
  endtask

`ifdef TEAM_06_ECHO_TIMEOUT_EN
  task automatic test_timeout();
    int lat; logic [7:0] eo; bit done; int rc0;
    apply_reset();
    run_sample(8'd10, 13'd0, 1'b0, 1'b0, lat, eo, done);
    rc0 = rd_count;
    hold_rd = 1'b1;
    run_sample(8'd90, 13'd1, 1'b1, 1'b0, lat, eo, done);
    hold_rd = 1'b0;
    checks++;
    if (mem_timeout !== 1'b1) begin failures++; $display("FAIL tmo_flag got=%b exp=1", mem_timeout); end
    checks++;
    if (eo !== 8'd90 || lat !== 66 || rd_count !== rc0) begin
      failures++;
      $display("FAIL tmo_echo got echo=%0d lat=%0d reads=%0d exp echo=90 lat=66 reads=0", eo, lat, rd_count - rc0);
    end
    checks++;
    if ({last_wr_addr, last_wr_data} !== {13'd1, 8'd90}) begin
      failures++;
      $display("FAIL tmo_write got addr=%0d data=%0d exp addr=1 data=90", last_wr_addr, last_wr_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_warmup();
    test_echo_read();
    test_saturation();
    test_overrun_reset();
    test_wrap();
`ifdef TEAM_06_ECHO_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/team_06_echo_engine.md
Name: team_06_echo_engine

Overview:
- Parametrised second-generation echo block with an owned circular history buffer, a read/write memory handshake and selectable single-tap or feedback echo.
- Accepts one audio sample per `sample_valid` strobe.
- Fetches the sample written `delay` samples earlier from external sample RAM, mixes it with the input, emits the result and writes back the value to remember.
- Sits between the audio input path and the output DAC/PWM stage, sharing the sample RAM port with no other block.

Parameters:
- SAMPLE_W, 8, audio sample width, unsigned.
- ADDR_W, 13, history RAM address width; depth = 2**ADDR_W.
- DECAY_SHIFT, 1, echo attenuation; the past sample is shifted right by this amount before mixing.
- TIMEOUT_CYC, 64, ack wait limit, used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sample_valid  in  1  one-cycle strobe, new audio_in present
- audio_in  in  SAMPLE_W  input sample
- echo_en  in  1  0 = bypass (out = in, still records history)
- feedback  in  1  0 = store audio_in, 1 = store mixed output
- delay  in  ADDR_W  echo distance in samples; sampled on accept
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  SAMPLE_W  write data
- mem_rdata  in  SAMPLE_W  read data, valid when mem_ack=1 on a read
- mem_ack  in  1  one-cycle completion pulse
- echo_out  out  SAMPLE_W  mixed output, held until next update
- out_valid  out  1  one-cycle pulse when echo_out updates
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky; a strobe arrived while busy; cleared only by rst

Behaviour:
- Reset: every output is 0, FSM = IDLE, wr_ptr = 0, fill count = 0.
  - rst mid-transaction drops mem_req the next cycle and discards the sample.
- FSM states are IDLE, RD_REQ, MIX, WR_REQ.
  - IDLE: on sample_valid, latch audio_in, delay, echo_en and feedback.
    - If echo_en=1, delay != 0 and fill >= delay, go to RD_REQ.
    - Otherwise past = 0 and go to MIX.
  - RD_REQ: mem_req=1, mem_we=0, mem_addr = wr_ptr - delay (mod 2**ADDR_W). On mem_ack, capture mem_rdata as past and go to MIX.
  - MIX (1 cycle): compute the result, then go to WR_REQ.
    - mix = audio + (past >> DECAY_SHIFT), computed in SAMPLE_W+1 bits and saturated to 2**SAMPLE_W - 1.
    - echo_en=0 gives mix = audio.
    - Register echo_out and pulse out_valid this cycle.
  - WR_REQ: mem_req=1, mem_we=1, mem_addr=wr_ptr, mem_wdata = feedback ? mix : audio. On mem_ack: wr_ptr += 1 (wraps at 2**ADDR_W), fill saturates at 2**ADDR_W - 1, go to IDLE.
- Latency:
  - Sample accept to out_valid is 2 cycles plus read-ack wait when reading.
  - Sample accept to out_valid is exactly 2 cycles when no read occurs.
  - busy deasserts the cycle after the write ack.
- Warm-up: while fill < delay the tap is empty, past = 0 and no read is issued.
- sample_valid while busy: the sample is dropped, overrun is set, and the state is unaffected.
- sample_valid in the same cycle the FSM returns to IDLE counts as busy and is dropped.
- mem_ack outside RD_REQ/WR_REQ is ignored.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1.

Optional Feature:
- Macro: TEAM_06_ECHO_TIMEOUT_EN.
- Defined:
  - A counter runs in RD_REQ/WR_REQ. After TIMEOUT_CYC cycles without mem_ack, mem_req drops and a sticky output port `mem_timeout` (1 bit, reset 0) sets.
  - A timed-out read uses past = 0 and continues to MIX.
  - A timed-out write leaves wr_ptr and fill unchanged and returns to IDLE.
- Undefined: no counter and no `mem_timeout` port; the FSM waits for mem_ack indefinitely.

Decomposition:
- Package team_06_echo_pkg holds:
  - the state enum typedef (IDLE, RD_REQ, MIX, WR_REQ);
  - default-width constants;
  - a saturating-add function parametrised on width.
- One sub-module, team_06_echo_mixer: combinational shift plus saturating add, reused by later effect blocks.

Test Plan:
- Reset then a strobe with audio_in=68, delay=4, echo_en=1 and fill=0:
  - no read is issued;
  - echo_out=68 and out_valid pulses 2 cycles after the strobe;
  - a write to addr 0 with data 68 follows.
- After 4 stored samples (10, 20, 30, 40), feed 100 with delay=4, DECAY_SHIFT=1 and the RAM model returning 10 with 3-cycle ack:
  - read addr = 0;
  - echo_out=105;
  - latency 5 cycles.
- Saturation: audio_in=250 with past=200 -> echo_out=255. With feedback=1 the write data is 255; with feedback=0 it is 250.
- Wrap: with wr_ptr=2**ADDR_W-1, a write completes -> wr_ptr=0; a following delay=3 read issues addr 2**ADDR_W-3.
- Overrun and reset:
  - A strobe during RD_REQ -> overrun=1 and the sample is discarded.
  - A second strobe after returning to IDLE is processed normally.
  - rst asserted during WR_REQ -> next cycle mem_req=0 and busy=0, wr_ptr unchanged at its reset value 0.
- With TEAM_06_ECHO_TIMEOUT_EN: ack withheld 64 cycles on a read -> mem_timeout=1, echo_out=audio_in, the write still occurs.
